// File: rtl/pwm_line_scheduler_pkg.sv
// Shared types and defaults for the PWM line scheduler and its shadow buffer.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    STALL = 2'd2,
    RUN   = 2'd3
  } sched_state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int LINE_CYCLES = 2 ** DEF_DATA_W;

endpackage

// File: rtl/pwm_line_scheduler_if.sv
// Duty byte stream into the scheduler: valid/ready handshake, one byte per transfer.
interface pwm_line_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic              data_ready;

  modport master (output data_valid, output data_in, input data_ready);
  modport slave  (input data_valid, input data_in, output data_ready);
endinterface

// File: rtl/pwm_line_scheduler_shadow_buf.sv
// Shadow duty registers with fill index; commit copies them (plus any same-cycle byte) to the live duty outputs.
module pwm_shadow_buf
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [DATA_W-1:0]        i_wr_dat,
  input  logic                     i_commit,
  output logic                     o_full,
  output logic                     o_full_next,
  output logic [NUM_CH*DATA_W-1:0] o_duty
);
  localparam int FILL_W = $clog2(NUM_CH + 1);

  logic [DATA_W-1:0]        r_shadow [NUM_CH];
  logic [FILL_W-1:0]        r_fill_idx;
  logic [NUM_CH*DATA_W-1:0] w_merged;

  assign o_full      = (r_fill_idx == FILL_W'(NUM_CH));
  assign o_full_next = o_full || (i_wr && (r_fill_idx == FILL_W'(NUM_CH - 1)));

  // Byte landing in the commit cycle must be part of the committed line.
  always_comb begin
    w_merged = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_merged[k*DATA_W +: DATA_W] = (i_wr && (r_fill_idx == FILL_W'(k))) ? i_wr_dat : r_shadow[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) r_shadow[k] <= '0;
      r_fill_idx <= '0;
      o_duty     <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_wr && (r_fill_idx == FILL_W'(k))) r_shadow[k] <= i_wr_dat;
      end
      if (i_commit) begin
        o_duty     <= w_merged;
        r_fill_idx <= '0;
      end else if (i_wr) begin
        r_fill_idx <= r_fill_idx + FILL_W'(1);
      end
    end
  end
endmodule

// File: rtl/pwm_line_scheduler.sv
// Row-scanned PWM line sequencer: blanking gap, 2**DATA_W-cycle display, double-buffered duties.
// Optional underrun counter on STALL entry under PWM_SCHED_UNDERRUN_CNT_EN.
module pwm_line_scheduler
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_ROWS   = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  pwm_line_scheduler_if.slave         s_if,
  output logic [NUM_CH*DATA_W-1:0]    duty,
  output logic                        cnt_rst,
  output logic                        hsync,
  output logic [$clog2(NUM_ROWS)-1:0] row_addr,
  output logic                        frame_done,
  output logic                        busy
`ifdef PWM_SCHED_UNDERRUN_CNT_EN
  ,
  input  logic                        underrun_clr,
  output logic [15:0]                 underrun_cnt
`endif
);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  sched_state_t      r_state;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [DATA_W-1:0] r_line_cnt;

  logic w_xfer, w_full, w_full_next, w_commit, w_gap_end, w_line_end;

  assign s_if.data_ready = busy && !w_full;
  assign w_xfer          = s_if.data_valid && s_if.data_ready;
  assign w_gap_end       = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign w_line_end      = &r_line_cnt;
  assign w_commit        = w_full_next && (((r_state == BLANK) && w_gap_end) || (r_state == STALL));

  pwm_shadow_buf #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .i_wr        (w_xfer),
    .i_wr_dat    (s_if.data_in),
    .i_commit    (w_commit),
    .o_full      (w_full),
    .o_full_next (w_full_next),
    .o_duty      (duty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gap_cnt  <= '0;
      r_line_cnt <= '0;
      row_addr   <= '0;
      frame_done <= 1'b0;
      hsync      <= 1'b0;
      cnt_rst    <= 1'b1;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state   <= BLANK;
            r_gap_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        BLANK, STALL: begin
          if ((r_state == BLANK) && !w_gap_end) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end else if (w_commit) begin
            r_state    <= RUN;
            r_line_cnt <= '0;
            hsync      <= 1'b1;
            cnt_rst    <= 1'b0;
          end else begin
            r_state <= STALL;
          end
        end
        RUN: begin
          r_line_cnt <= r_line_cnt + DATA_W'(1);
          if (w_line_end) begin
            hsync     <= 1'b0;
            cnt_rst   <= 1'b1;
            r_gap_cnt <= '0;
            if (row_addr == ROW_W'(NUM_ROWS - 1)) begin
              row_addr   <= '0;
              frame_done <= 1'b1;
            end else begin
              row_addr <= row_addr + ROW_W'(1);
            end
            // Partial shadow contents survive a trip through IDLE.
            if (enable) begin
              r_state <= BLANK;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PWM_SCHED_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun_clr) begin
      underrun_cnt <= '0;
    end else if ((r_state == BLANK) && w_gap_end && !w_commit && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif
endmodule
